// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: Data_T/LS codes, states,
// and the byte-enable / lane-replication arithmetic.
package lsu_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        DT_SW  = 3'b000,
        DT_SH  = 3'b001,
        DT_SB  = 3'b010,
        DT_LBU = 3'b011,
        DT_LW  = 3'b100,
        DT_LB  = 3'b101,
        DT_LH  = 3'b110,
        DT_LHU = 3'b111
    } data_t_e;

    typedef enum logic [1:0] {
        LS_NONE  = 2'b00,
        LS_LOAD  = 2'b01,
        LS_STORE = 2'b10,
        LS_RSVD  = 2'b11
    } ls_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    function automatic size_e access_size(input logic [2:0] dt);
        size_e sz;
        case (dt)
            DT_SB, DT_LB, DT_LBU: sz = SZ_BYTE;
            DT_SH, DT_LH, DT_LHU: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        return (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
    endfunction

    // Offending low bits are dropped so halves/words land on their natural lanes.
    function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] lo);
        logic [1:0] r;
        case (sz)
            SZ_BYTE: r = lo;
            SZ_HALF: r = {lo[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lo);
        logic [3:0] r;
        case (sz)
            SZ_BYTE: r = 4'b0001 << lo;
            SZ_HALF: r = 4'b0011 << {lo[1], 1'b0};
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_rep(input size_e sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word-wide data-memory port with request/grant and read-valid handshake.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction with sign/zero extension by Data_T.
module lsu_load_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  data_t,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (data_t)
            DT_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            DT_LBU:  result = {24'h000000, byte_lane};
            DT_LH:   result = {{16{half_lane[15]}}, half_lane};
            DT_LHU:  result = {16'h0000, half_lane};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: latches one access, runs the memory handshake, returns extended
// load data. Optional misalignment trap under LSU_MISALIGN_TRAP_EN.
//   state   | meaning
//   IDLE    | waiting for LS load/store
//   REQ     | mem_req high until grant or timeout
//   WAIT    | load granted, waiting for mem_rvalid or timeout
//   DONE    | one-cycle done (and bus_err on timeout/trap)
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        LS,
    input  logic [2:0]        Data_T,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              bus_err,
    lsu_mem_ctrl_if.master    mem
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              store_q;
    logic [2:0]        dt_q;
    logic [1:0]        lo_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       align_res;

    size_e             acc_size;
    logic [1:0]        acc_lo;
    logic              accept;
    logic              trap;
    logic              timeout_hit;

    assign acc_size    = access_size(Data_T);
    assign acc_lo      = align_lo(acc_size, addr[1:0]);
    assign accept      = (state_q == ST_IDLE) && (LS == LS_LOAD || LS == LS_STORE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(acc_size, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Grant beats rvalid in REQ; a response beats the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (trap) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    state_d = store_q ? ST_DONE : ST_WAIT;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            dt_q    <= 3'b000;
            lo_q    <= 2'b00;
            maddr_q <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            store_q <= (LS == LS_STORE);
            dt_q    <= Data_T;
            lo_q    <= acc_lo;
            maddr_q <= {addr[ADDR_W-1:2], 2'b00};
            be_q    <= byte_en(acc_size, acc_lo);
            wdata_q <= lane_rep(acc_size, wdata);
            rdata_q <= 32'h0;
        end else if (state_q == ST_WAIT && mem.mem_rvalid) begin
            rdata_q <= align_res;
        end
    end

    lsu_load_align u_load_align (
        .data_t    (dt_q),
        .addr_lo   (lo_q),
        .mem_rdata (mem.mem_rdata),
        .result    (align_res)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign bus_err       = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = store_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (TIMEOUT=4): loads, stores, timeouts, misalignment, reset.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ls;
    logic [2:0]  data_t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) mem ();

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .LS      (ls),
        .Data_T  (data_t),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .bus_err (bus_err),
        .mem     (mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One access with an ideal/delayed memory. Core inputs are scrambled after acceptance
    // so the latched copy must govern. decoy raises rvalid together with the grant.
    task automatic xact(input string tag, input logic [1:0] op, input logic [2:0] dt,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int gnt_wait, input bit decoy, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
        ls = op; data_t = dt; addr = a; wdata = wd;
        tick();
        ls = 2'b00; data_t = ~dt; addr = ~a; wdata = ~wd;
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        chk({tag, "_req"}, 32'(mem.mem_req), 32'h1);
        chk({tag, "_we"}, 32'(mem.mem_we), (op == LS_STORE) ? 32'h1 : 32'h0);
        chk({tag, "_addr"}, mem.mem_addr, exp_addr);
        chk({tag, "_be"}, 32'(mem.mem_be), 32'(exp_be));
        if (op == LS_STORE) chk({tag, "_wdata"}, mem.mem_wdata, exp_wdata);
        repeat (gnt_wait) tick();
        if (gnt_wait > 0) chk({tag, "_req_held"}, 32'(mem.mem_req), 32'h1);
        mem.mem_gnt = 1'b1;
        if (decoy) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = 32'hDEADBEEF;
        end
        tick();
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0;
        if (op == LS_LOAD) begin
            chk({tag, "_wait_req"}, 32'(mem.mem_req), 32'h0);
            chk({tag, "_wait_done"}, 32'(done), 32'h0);
            if (decoy) begin
                tick();
                chk({tag, "_decoy_done"}, 32'(done), 32'h0);
            end
            mem.mem_rvalid = 1'b1; mem.mem_rdata = word;
            tick();
            mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0;
        end
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_done_busy"}, 32'(busy), 32'h1);
        chk({tag, "_err"}, 32'(bus_err), 32'h0);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'h0);
        chk({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ls = 2'b00; data_t = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", 32'(mem.mem_req), 32'h0);
        chk("rst_we", 32'(mem.mem_we), 32'h0);
        chk("rst_addr", mem.mem_addr, 32'h0);
        chk("rst_be", 32'(mem.mem_be), 32'h0);
        chk("rst_wdata", mem.mem_wdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // LB: done in the 4th cycle counting the acceptance cycle (accept, REQ, WAIT, DONE)
        xact("lb", LS_LOAD, DT_LB, 32'h103, 32'h0, 32'h80000000, 0, 1'b0,
             32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        xact("lhu", LS_LOAD, DT_LHU, 32'h102, 32'h0, 32'h80011234, 0, 1'b1,
             32'h100, 4'b1100, 32'h0, 32'h00008001);
        xact("lh", LS_LOAD, DT_LH, 32'h106, 32'h0, 32'h80011234, 0, 1'b0,
             32'h104, 4'b1100, 32'h0, 32'hFFFF8001);
        xact("lbu", LS_LOAD, DT_LBU, 32'h10A, 32'h0, 32'h00C30000, 1, 1'b0,
             32'h108, 4'b0100, 32'h0, 32'h000000C3);
        // grant arrives in the last REQ cycle before the timeout would fire
        xact("sb", LS_STORE, DT_SB, 32'h201, 32'h000000A5, 32'h0, 3, 1'b0,
             32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0);
        xact("sh", LS_STORE, DT_SH, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0,
             32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
        xact("sw", LS_STORE, DT_SW, 32'h2F4, 32'h12345678, 32'h0, 0, 1'b0,
             32'h2F4, 4'b1111, 32'h12345678, 32'h0);

        // grant never comes: REQ lasts TIMEOUT cycles
        ls = LS_LOAD; data_t = DT_LW; addr = 32'h400;
        tick();
        ls = 2'b00;
        repeat (3) tick();
        chk("to_req_req", 32'(mem.mem_req), 32'h1);
        chk("to_req_early", 32'(done), 32'h0);
        tick();
        chk("to_req_done", 32'(done), 32'h1);
        chk("to_req_err", 32'(bus_err), 32'h1);
        chk("to_req_rdata", rdata, 32'h0);
        chk("to_req_reqlow", 32'(mem.mem_req), 32'h0);
        tick();
        chk("to_req_err_drop", 32'(bus_err), 32'h0);
        chk("to_req_idle", 32'(busy), 32'h0);
        xact("after_to", LS_LOAD, DT_LW, 32'h404, 32'h0, 32'hCAFEF00D, 0, 1'b0,
             32'h404, 4'b1111, 32'h0, 32'hCAFEF00D);

        // granted but rvalid never comes: WAIT lasts TIMEOUT cycles
        ls = LS_LOAD; data_t = DT_LW; addr = 32'h408;
        tick();
        ls = 2'b00; mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        repeat (3) tick();
        chk("to_wait_early", 32'(done), 32'h0);
        tick();
        chk("to_wait_done", 32'(done), 32'h1);
        chk("to_wait_err", 32'(bus_err), 32'h1);
        chk("to_wait_rdata", rdata, 32'h0);
        tick();

`ifdef LSU_MISALIGN_TRAP_EN
        ls = LS_LOAD; data_t = DT_LW; addr = 32'h302;
        tick();
        ls = 2'b00;
        chk("mis_done", 32'(done), 32'h1);
        chk("mis_err", 32'(bus_err), 32'h1);
        chk("mis_req", 32'(mem.mem_req), 32'h0);
        chk("mis_rdata", rdata, 32'h0);
        tick();
        chk("mis_idle", 32'(busy), 32'h0);
        chk("mis_req_after", 32'(mem.mem_req), 32'h0);
`else
        xact("lw_mis", LS_LOAD, DT_LW, 32'h302, 32'h0, 32'h11223344, 0, 1'b0,
             32'h300, 4'b1111, 32'h0, 32'h11223344);
        xact("sh_mis", LS_STORE, DT_SH, 32'h203, 32'h0000BEEF, 32'h0, 0, 1'b0,
             32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0);
`endif

        // reset while in WAIT
        ls = LS_LOAD; data_t = DT_LBU; addr = 32'h501;
        tick();
        ls = 2'b00; mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        chk("rw_pre_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 32'h0);
        chk("rw_req", 32'(mem.mem_req), 32'h0);
        chk("rw_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h0000F000;
        tick();
        mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0;
        chk("rw_stray_done", 32'(done), 32'h0);
        chk("rw_stray_busy", 32'(busy), 32'h0);
        xact("rw_next", LS_LOAD, DT_LBU, 32'h501, 32'h0, 32'h0000F000, 0, 1'b0,
             32'h500, 4'b0010, 32'h0, 32'h000000F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
